// File: rtl/cache_req_arbiter_upstream.sv
// Round-robin arbiter that shares one upstream cache FSM among NREQ requesters.
// Latency: grant is combinational in IDLE; the cache sees the request the next cycle; the response is held until accepted.
// Backpressure: one transaction in flight; resp_valid holds until resp_ready, and no new grant is made until then.
module cache_req_arbiter_upstream #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_addr,
  input  logic [NREQ*32-1:0]      req_data,
  input  logic [NREQ-1:0]         req_rw,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [31:0]             resp_data,
  output logic [31:0]             cpu_req_addr,
  output logic [31:0]             cpu_req_data,
  output logic                    cpu_req_rw,
  output logic                    cpu_req_valid,
  input  logic [31:0]             cpu_res_data,
  input  logic                    cpu_res_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err_timeout
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          grant;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_data;
  logic          sel_rw;
  logic [31:0]   hold_addr;
  logic [31:0]   hold_data;
  logic          hold_rw;
  logic [31:0]   resp_reg;
  logic [CW-1:0] wait_cnt;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Select the winning requester's address, data and direction for latching.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        sel_addr = req_addr[32*k +: 32];
        sel_data = req_data[32*k +: 32];
        sel_rw   = req_rw[k];
      end
    end
  end

  // The grant pulse is gated by rst so no requester sees an accept while reset is held.
  assign grant         = (state == S_IDLE) && found && !rst;
  assign req_ready     = grant ? (NREQ'(1) << win) : '0;
  assign resp_valid    = (state == S_RESP) ? (NREQ'(1) << grant_id) : '0;
  assign cpu_req_valid = (state == S_WAIT);
  assign cpu_req_addr  = hold_addr;
  assign cpu_req_data  = hold_data;
  assign cpu_req_rw    = hold_rw;
  assign resp_data     = resp_reg;

  // Transaction FSM: grant in IDLE, hold the request in WAIT, present the response in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_rw     <= 1'b0;
      resp_reg    <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            hold_addr <= sel_addr;
            hold_data <= sel_data;
            hold_rw   <= sel_rw;
            grant_id  <= win;
            rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter saturates; the flag is sticky and the transaction keeps waiting.
          if (wait_cnt != CW'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
          if (wait_cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
          end
          if (cpu_res_ready) begin
            resp_reg <= cpu_res_data;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[grant_id]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter_upstream.sv
// Self-checking bench for cache_req_arbiter_upstream: directed table, reset corner cases, random transactions.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// The reference model works per transaction: round-robin winner, expected request fields, response and timeout flag.
module tb_cache_req_arbiter_upstream;

  localparam int NREQ = 4;
  localparam int TO   = 255;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_addr;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_rw;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [31:0]         resp_data;
  logic [31:0]         cpu_req_addr;
  logic [31:0]         cpu_req_data;
  logic                cpu_req_rw;
  logic                cpu_req_valid;
  logic [31:0]         cpu_res_data;
  logic                cpu_res_ready;
  logic [1:0]          grant_id;
  logic                err_timeout;

  cache_req_arbiter_upstream #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
    .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
    .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] vmask;
    int              g;
    int              lat;
    int              bp;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            rw;
  } vec_t;

  vec_t tbl[16];

  int nvec = 0;
  int nerr = 0;
  int ptr_m = 0;
  bit err_m = 1'b0;

  logic [31:0]     fa[NREQ];
  logic [31:0]     fd[NREQ];
  logic [NREQ-1:0] frw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[32*i +: 32] = fa[i];
      req_data[32*i +: 32] = fd[i];
      req_rw[i]            = frw[i];
    end
  endtask

  // Random fields everywhere, then the chosen requester gets the given values.
  task automatic set_fields(input int g, input logic [31:0] a, input logic [31:0] d, input logic rw);
    for (int i = 0; i < NREQ; i++) begin
      fa[i]  = $urandom;
      fd[i]  = $urandom;
      frw[i] = 1'($urandom_range(0, 1));
    end
    if (g >= 0) begin
      fa[g]  = a;
      fd[g]  = d;
      frw[g] = rw;
    end
  endtask

  // Reference rule: first valid requester at or after the round-robin pointer.
  function automatic int model_win(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  // One whole transaction: grant cycle, lat WAIT cycles (ready on the last), bp stalled RESP cycles then accept.
  task automatic run_txn(input logic [NREQ-1:0] vmask, input int exp_g, input int lat, input int bp,
                         input logic [31:0] cdata, input bit scramble);
    logic [31:0] ea, ed, rd0;
    logic        erw;
    @(negedge clk);
    req_valid     = vmask;
    drive_fields();
    resp_ready    = '0;
    cpu_res_ready = 1'b0;
    cpu_res_data  = $urandom;
    #1;
    if (exp_g < 0) begin
      chk("idle_req_ready", 32'(req_ready), 32'h0);
      chk("idle_cpu_valid", 32'(cpu_req_valid), 32'h0);
      return;
    end
    chk("grant_req_ready", 32'(req_ready), 32'h1 << exp_g);
    chk("grant_cpu_valid", 32'(cpu_req_valid), 32'h0);
    chk("grant_resp_valid", 32'(resp_valid), 32'h0);
    ea  = fa[exp_g];
    ed  = fd[exp_g];
    erw = frw[exp_g];
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (scramble) begin
        req_valid = NREQ'($urandom);
        set_fields(-1, 32'h0, 32'h0, 1'b0);
        drive_fields();
        resp_ready = NREQ'($urandom);
      end
      cpu_res_ready = (c == lat);
      cpu_res_data  = (c == lat) ? cdata : $urandom;
      #1;
      chk("wait_cpu_valid", 32'(cpu_req_valid), 32'h1);
      chk("wait_addr", cpu_req_addr, ea);
      chk("wait_data", cpu_req_data, ed);
      chk("wait_rw", 32'(cpu_req_rw), 32'(erw));
      chk("wait_grant_id", 32'(grant_id), 32'(exp_g));
      chk("wait_req_ready", 32'(req_ready), 32'h0);
      chk("wait_resp_valid", 32'(resp_valid), 32'h0);
      chk("wait_err_timeout", 32'(err_timeout), 32'(err_m || (c > TO)));
    end
    if (lat >= TO) err_m = 1'b1;
    for (int c = 0; c <= bp; c++) begin
      @(negedge clk);
      resp_ready        = scramble ? NREQ'($urandom) : '0;
      resp_ready[exp_g] = (c == bp);
      cpu_res_ready     = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_res_data      = $urandom;
      if (scramble) req_valid = NREQ'($urandom);
      #1;
      chk("resp_valid", 32'(resp_valid), 32'h1 << exp_g);
      chk("resp_cpu_valid", 32'(cpu_req_valid), 32'h0);
      chk("resp_req_ready", 32'(req_ready), 32'h0);
      chk("resp_grant_id", 32'(grant_id), 32'(exp_g));
      chk("resp_err_timeout", 32'(err_timeout), 32'(err_m));
      if (!erw) chk("resp_data", resp_data, cdata);
      if (c == 0) rd0 = resp_data;
      else chk("resp_data_stable", resp_data, rd0);
    end
    ptr_m = (exp_g + 1) % NREQ;
  endtask

  initial begin
    // Directed table: expected winners worked out by hand from the round-robin rule.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{4'hF, i % 4, 1 + (i % 3), i % 2, 32'h100 + 32'(i * 4), 32'(i), 32'hA000_0000 + 32'(i), 1'(i % 2)};
    end
    tbl[8]  = '{4'b0001,  0,   3, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0};
    tbl[9]  = '{4'b0010,  1,   2, 5, 32'h0000_0020, 32'h0,         32'hCAFE_0001, 1'b0};
    tbl[10] = '{4'b0100,  2,   4, 0, 32'h0000_0040, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1};
    tbl[11] = '{4'b0011,  0,   1, 1, 32'h0000_0080, 32'h0,         32'h5555_AAAA, 1'b0};
    tbl[12] = '{4'b1001,  3,   2, 0, 32'h0000_0090, 32'h0000_0077, 32'h0BAD_F00D, 1'b1};
    tbl[13] = '{4'b1000,  3,   1, 2, 32'h0000_00A0, 32'h0,         32'h7777_0000, 1'b0};
    tbl[14] = '{4'b0000, -1,   0, 0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[15] = '{4'b0001,  0, 300, 1, 32'h0000_00C0, 32'h0,         32'h0F0F_0F0F, 1'b0};

    // Reset state, with every requester asking so a leaked grant would show.
    rst           = 1'b1;
    req_valid     = 4'hF;
    resp_ready    = '0;
    cpu_res_ready = 1'b0;
    cpu_res_data  = 32'hFFFF_FFFF;
    set_fields(-1, 32'h0, 32'h0, 1'b0);
    drive_fields();
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_cpu_valid", 32'(cpu_req_valid), 32'h0);
    chk("rst_cpu_addr", cpu_req_addr, 32'h0);
    chk("rst_cpu_data", cpu_req_data, 32'h0);
    chk("rst_cpu_rw", 32'(cpu_req_rw), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;

    foreach (tbl[i]) begin
      set_fields(tbl[i].g, tbl[i].addr, tbl[i].wdata, tbl[i].rw);
      run_txn(tbl[i].vmask, tbl[i].g, tbl[i].lat, tbl[i].bp, tbl[i].rdata, 1'b0);
    end

    // Reset in the second WAIT cycle: request drops at once, no response, requester 0 wins afterwards.
    begin
      int g;
      @(negedge clk);
      set_fields(-1, 32'h0, 32'h0, 1'b0);
      drive_fields();
      req_valid = 4'b0110;
      g = model_win(req_valid);
      #1;
      chk("midrst_grant", 32'(req_ready), 32'h1 << g);
      @(negedge clk);
      #1;
      chk("midrst_wait1_valid", 32'(cpu_req_valid), 32'h1);
      @(negedge clk);
      #1;
      chk("midrst_wait2_valid", 32'(cpu_req_valid), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_cpu_valid", 32'(cpu_req_valid), 32'h0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      chk("midrst_grant_id", 32'(grant_id), 32'h0);
      chk("midrst_err_cleared", 32'(err_timeout), 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      #1;
      chk("postrst_resp_valid", 32'(resp_valid), 32'h0);
      chk("postrst_cpu_valid", 32'(cpu_req_valid), 32'h0);
      ptr_m = 0;
      err_m = 1'b0;
      set_fields(0, 32'h0000_0300, 32'h0, 1'b0);
      run_txn(4'hF, 0, 2, 1, 32'h3333_4444, 1'b0);
    end

    // Random transactions against the reference model, with inputs scrambled after the grant.
    for (int n = 0; n < 80; n++) begin
      logic [NREQ-1:0] m;
      int g;
      m = NREQ'($urandom_range(0, 15));
      g = model_win(m);
      set_fields(g, $urandom, $urandom, 1'($urandom_range(0, 1)));
      run_txn(m, g, $urandom_range(1, 6), $urandom_range(0, 3), $urandom, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
